// File: rtl/prop_monitor.sv
// Bounded property monitor: records first firing of each flag over a BOUND-sample window
// and terminates in PASS on window expiry or FAIL as soon as a safety flag fires.
module prop_monitor #(
    parameter int unsigned BOUND     = 32,
    parameter int unsigned CNT_W     = 8,
    parameter logic [3:0]  SAFE_MASK = 4'b0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               z1,
    input  logic               z2,
    input  logic               z3,
    input  logic               z4,
    output logic [3:0]         hit,
    output logic [4*CNT_W-1:0] first_cyc,
    output logic [CNT_W-1:0]   cyc,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [CNT_W-1:0]   fail_cyc
);

    typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

    state_e             state_q, state_d;
    logic [3:0]         hit_q, hit_d;
    logic [4*CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   fail_cyc_q, fail_cyc_d;
    logic [3:0]         z;

    assign z = {z4, z3, z2, z1};

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        first_d    = first_q;
        cyc_d      = cyc_q;
        fail_cyc_d = fail_cyc_q;
        if (state_q == StRun) begin
            for (int i = 0; i < 4; i++) begin
                if (z[i] && !hit_q[i]) begin
                    hit_d[i]                  = 1'b1;
                    first_d[i*CNT_W +: CNT_W] = cyc_q;
                end
            end
            cyc_d = cyc_q + 1'b1;
            // Violation takes priority over window end on the same sample.
            if (|(z & SAFE_MASK)) begin
                state_d    = StFail;
                fail_cyc_d = cyc_q;
            end else if (cyc_q == CNT_W'(BOUND - 1)) begin
                state_d = StPass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StRun;
            hit_q      <= '0;
            first_q    <= '0;
            cyc_q      <= '0;
            fail_cyc_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            first_q    <= first_d;
            cyc_q      <= cyc_d;
            fail_cyc_q <= fail_cyc_d;
        end
    end

    assign hit       = hit_q;
    assign first_cyc = first_q;
    assign cyc       = cyc_q;
    assign fail_cyc  = fail_cyc_q;
    assign pass      = (state_q == StPass);
    assign fail      = (state_q == StFail);
    assign done      = pass | fail;

endmodule

// File: tb/tb_prop_monitor.sv
// Directed bench for prop_monitor: per-cycle comparison against a window model plus
// hand-computed expectations for each scenario.
module tb_prop_monitor;

    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          z1, z2, z3, z4;
    logic [3:0]    hit;
    logic [4*CW-1:0] first_cyc;
    logic [CW-1:0] cyc, fail_cyc;
    logic          done, pass, fail;

    logic [3:0]    b1_hit;
    logic [4*CW-1:0] b1_first;
    logic [CW-1:0] b1_cyc, b1_fail_cyc;
    logic          b1_done, b1_pass, b1_fail;

    int total = 0;
    int bad   = 0;

    // Window model
    int m_hit[4];
    int m_first[4];
    int m_cyc, m_pass, m_fail, m_fail_cyc;

    prop_monitor #(.BOUND(32), .CNT_W(CW), .SAFE_MASK(4'b0100)) u_dut (
        .clk(clk), .reset(reset), .z1(z1), .z2(z2), .z3(z3), .z4(z4),
        .hit(hit), .first_cyc(first_cyc), .cyc(cyc), .done(done),
        .pass(pass), .fail(fail), .fail_cyc(fail_cyc)
    );

    prop_monitor #(.BOUND(1), .CNT_W(CW), .SAFE_MASK(4'b0100)) u_b1 (
        .clk(clk), .reset(reset), .z1(z1), .z2(z2), .z3(z3), .z4(z4),
        .hit(b1_hit), .first_cyc(b1_first), .cyc(b1_cyc), .done(b1_done),
        .pass(b1_pass), .fail(b1_fail), .fail_cyc(b1_fail_cyc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int slice(input logic [4*CW-1:0] v, input int i);
        return int'(v[i*CW +: CW]);
    endfunction

    // Model advances with the stimulus, before the edge that samples it.
    task automatic model_step(input logic r, input logic [3:0] z);
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_hit[i]   = 0;
                m_first[i] = 0;
            end
            m_cyc = 0; m_pass = 0; m_fail = 0; m_fail_cyc = 0;
        end else if (m_pass == 0 && m_fail == 0) begin
            int k;
            k = m_cyc;
            for (int i = 0; i < 4; i++) begin
                if (z[i] && m_hit[i] == 0) begin
                    m_hit[i]   = 1;
                    m_first[i] = k;
                end
            end
            m_cyc = k + 1;
            if (z[2]) begin
                m_fail     = 1;
                m_fail_cyc = k;
            end else if (m_cyc == 32) begin
                m_pass = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] z);
        reset = r;
        {z4, z3, z2, z1} = z;
        model_step(r, z);
        @(negedge clk);
    endtask

    task automatic run_window(input int k3a, input logic [3:0] za, input int k3b,
                              input logic [3:0] zb, input int n);
        for (int k = 0; k < n; k++) begin
            if (k == k3a) step(1'b1, za);
            else if (k == k3b) step(1'b1, zb);
            else step(1'b1, 4'b0000);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("cyc", int'(cyc), m_cyc);
        chk("pass", int'(pass), m_pass);
        chk("fail", int'(fail), m_fail);
        chk("done", int'(done), (m_pass != 0 || m_fail != 0) ? 1 : 0);
        for (int i = 0; i < 4; i++) begin
            chk("hit", int'(hit[i]), m_hit[i]);
            if (m_hit[i] != 0) chk("first_cyc", slice(first_cyc, i), m_first[i]);
        end
        if (m_fail != 0) chk("fail_cyc", int'(fail_cyc), m_fail_cyc);
    end

    initial begin
        // Reset hold with all flags high
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111);
        chk("rst_hit", int'(hit), 0);
        chk("rst_cyc", int'(cyc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_first", int'(first_cyc), 0);
        step(1'b1, 4'b0000);
        chk("b1_pass", int'(b1_pass), 1);
        chk("b1_cyc", int'(b1_cyc), 1);
        run_window(-1, 4'b0, -1, 4'b0, 31);
        chk("idle_pass", int'(pass), 1);
        chk("idle_done", int'(done), 1);
        chk("idle_cyc", int'(cyc), 32);
        chk("idle_hit", int'(hit), 0);

        // Cover recording, z1 twice
        step(1'b0, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            if (k == 4 || k == 9) step(1'b1, 4'b0001);
            else if (k == 10) step(1'b1, 4'b0010);
            else step(1'b1, 4'b0000);
        end
        chk("cov_hit", int'(hit), 3);
        chk("cov_first0", slice(first_cyc, 0), 4);
        chk("cov_first1", slice(first_cyc, 1), 10);
        chk("cov_pass", int'(pass), 1);

        // Violation, then ignored activity
        step(1'b0, 4'b0000);
        run_window(7, 4'b0100, -1, 4'b0, 8);
        chk("vio_fail", int'(fail), 1);
        chk("vio_fail_cyc", int'(fail_cyc), 7);
        chk("vio_hit", int'(hit), 4);
        chk("vio_cyc", int'(cyc), 8);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1111);
        chk("frz_hit", int'(hit), 4);
        chk("frz_cyc", int'(cyc), 8);
        chk("frz_pass", int'(pass), 0);
        chk("frz_first2", slice(first_cyc, 2), 7);

        // Violation on the last sample
        step(1'b0, 4'b0000);
        run_window(31, 4'b0100, -1, 4'b0, 32);
        chk("last_fail", int'(fail), 1);
        chk("last_pass", int'(pass), 0);
        chk("last_fail_cyc", int'(fail_cyc), 31);
        chk("last_cyc", int'(cyc), 32);

        // Cover on the last sample
        step(1'b0, 4'b0000);
        run_window(31, 4'b0001, -1, 4'b0, 32);
        chk("lastc_pass", int'(pass), 1);
        chk("lastc_first0", slice(first_cyc, 0), 31);

        // Simultaneous first firings
        step(1'b0, 4'b0000);
        run_window(3, 4'b1011, -1, 4'b0, 32);
        chk("sim_hit", int'(hit), 11);
        chk("sim_first0", slice(first_cyc, 0), 3);
        chk("sim_first1", slice(first_cyc, 1), 3);
        chk("sim_first3", slice(first_cyc, 3), 3);
        chk("sim_pass", int'(pass), 1);

        // Reset after violation
        step(1'b0, 4'b0000);
        run_window(5, 4'b0100, -1, 4'b0, 6);
        chk("mid_fail", int'(fail), 1);
        step(1'b0, 4'b0000);
        chk("mid_rst_fail", int'(fail), 0);
        chk("mid_rst_cyc", int'(cyc), 0);
        run_window(2, 4'b1000, -1, 4'b0, 32);
        chk("mid_fail2", int'(fail), 0);
        chk("mid_hit", int'(hit), 8);
        chk("mid_first3", slice(first_cyc, 3), 2);
        chk("mid_pass", int'(pass), 1);

        // Reset mid-run (no terminal state), then generator-like pattern
        step(1'b0, 4'b0000);
        run_window(-1, 4'b0, -1, 4'b0, 10);
        step(1'b0, 4'b0000);
        run_window(5, 4'b0001, 11, 4'b0011, 32);
        chk("gen_hit", int'(hit), 3);
        chk("gen_first0", slice(first_cyc, 0), 5);
        chk("gen_first1", slice(first_cyc, 1), 11);
        chk("gen_pass", int'(pass), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
